// File: rtl/reg_wb_pkg.sv
// Shared types and widths for the register-file writeback front end.
package reg_wb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/reg_wb_fifo.sv
// Dual-push (A older than B), single-pop queue of writeback entries; exposes
// per-entry valid and age (0 = head) so the top can search for the youngest match.
module reg_wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned PW   = AW + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push_a,
    input  wb_entry_t                   i_entry_a,
    input  logic                        i_push_b,
    input  wb_entry_t                   i_entry_b,
    input  logic                        i_pop,
    output logic [PW-1:0]               o_count,
    output wb_entry_t                   o_head,
    output wb_entry_t [DEPTH-1:0]       o_entries,
    output logic [DEPTH-1:0]            o_valid,
    output logic [DEPTH-1:0][AW-1:0]    o_age
);

    wb_entry_t [DEPTH-1:0] r_mem;
    logic [PW-1:0]         r_wr;
    logic [PW-1:0]         r_rd;
    logic [PW-1:0]         w_wr_b;

    // B lands one slot past A when both push in the same cycle.
    assign w_wr_b = r_wr + PW'(i_push_a);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            r_wr <= r_wr + PW'(i_push_a) + PW'(i_push_b);
            if (i_pop) begin
                r_rd <= r_rd + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_push_a) begin
            r_mem[r_wr[AW-1:0]] <= i_entry_a;
        end
        if (i_push_b) begin
            r_mem[w_wr_b[AW-1:0]] <= i_entry_b;
        end
    end

    assign o_count   = r_wr - r_rd;
    assign o_head    = r_mem[r_rd[AW-1:0]];
    assign o_entries = r_mem;

    always_comb begin
        o_age   = '0;
        o_valid = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_age[i]   = AW'(i) - r_rd[AW-1:0];
            o_valid[i] = PW'(o_age[i]) < o_count;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback merge queue: x0 filtering, ready, drain and lookup.
// Optional forwarding of pending writes is enabled by defining REG_WB_BYPASS_EN.
module reg_writeback
    import reg_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_AW-1:0] a_rd,
    input  logic [XLEN-1:0]   a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_AW-1:0] b_rd,
    input  logic [XLEN-1:0]   b_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_a3,
    output logic [XLEN-1:0]   rf_wd3,
    input  logic [REG_AW-1:0] q1_addr,
    output logic              q1_hit,
    output logic [XLEN-1:0]   q1_data,
    input  logic [REG_AW-1:0] q2_addr,
    output logic              q2_hit,
    output logic [XLEN-1:0]   q2_data,
    output logic              busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] READY_MAX = PW'(DEPTH - 2);

    logic [PW-1:0]            w_count;
    logic                     w_ready;
    logic                     w_push_a;
    logic                     w_push_b;
    wb_entry_t                w_head;
    wb_entry_t [DEPTH-1:0]    w_entries;
    logic [DEPTH-1:0]         w_valid;
    logic [DEPTH-1:0][AW-1:0] w_age;

    // Ready uses the pre-pop count so a paired A+B push always fits.
    assign w_ready  = w_count <= READY_MAX;
    assign a_ready  = w_ready;
    assign b_ready  = w_ready;
    assign w_push_a = a_valid && w_ready && (a_rd != '0);
    assign w_push_b = b_valid && w_ready && (b_rd != '0);
    assign busy     = w_count != '0;

    reg_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push_a (w_push_a),
        .i_entry_a('{rd: a_rd, data: a_data}),
        .i_push_b (w_push_b),
        .i_entry_b('{rd: b_rd, data: b_data}),
        .i_pop    (busy),
        .o_count  (w_count),
        .o_head   (w_head),
        .o_entries(w_entries),
        .o_valid  (w_valid),
        .o_age    (w_age)
    );

    assign rf_we  = busy;
    assign rf_a3  = w_head.rd;
    assign rf_wd3 = w_head.data;

`ifdef REG_WB_BYPASS_EN
    function automatic logic [XLEN:0] f_lookup(
        input logic [REG_AW-1:0]          addr,
        input wb_entry_t [DEPTH-1:0]      entries,
        input logic [DEPTH-1:0]           valid,
        input logic [DEPTH-1:0][AW-1:0]   age
    );
        logic            hit;
        logic [XLEN-1:0] data;
        logic [AW-1:0]   best;
        hit  = 1'b0;
        data = '0;
        best = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid[i] && entries[i].rd == addr && (!hit || age[i] > best)) begin
                hit  = 1'b1;
                best = age[i];
                data = entries[i].data;
            end
        end
        if (addr == '0) begin
            hit  = 1'b0;
            data = '0;
        end
        return {hit, data};
    endfunction

    assign {q1_hit, q1_data} = f_lookup(q1_addr, w_entries, w_valid, w_age);
    assign {q2_hit, q2_data} = f_lookup(q2_addr, w_entries, w_valid, w_age);
`else
    logic w_unused_lookup;
    assign w_unused_lookup = ^{w_entries, w_valid, w_age, q1_addr, q2_addr};
    assign q1_hit  = 1'b0;
    assign q1_data = '0;
    assign q2_hit  = 1'b0;
    assign q2_data = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback (DEPTH=4); lookup expectations
// follow REG_WB_BYPASS_EN.
module tb_reg_writeback;

    logic        clk;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_rd, b_rd;
    logic [31:0] a_data, b_data;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic [4:0]  q1_addr, q2_addr;
    logic        q1_hit, q2_hit;
    logic [31:0] q1_data, q2_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    reg_writeback #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
        .q1_addr(q1_addr), .q1_hit(q1_hit), .q1_data(q1_data),
        .q2_addr(q2_addr), .q2_hit(q2_hit), .q2_data(q2_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; b_valid = 1'b0;
        a_rd = '0; b_rd = '0; a_data = '0; b_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        q1_addr = '0; q2_addr = '0;
        rst_n = 1'b0;
        step(); step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b exp=0", rf_we); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if ({a_ready, b_ready} !== 2'b11) begin bad++; $display("FAIL reset_ready got=%b exp=11", {a_ready, b_ready}); end
        total++; if ({q1_hit, q2_hit} !== 2'b00) begin bad++; $display("FAIL reset_hit got=%b exp=00", {q1_hit, q2_hit}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h11;
        step();
        idle_inputs();
        total++; if ({rf_we, rf_a3, rf_wd3} !== {1'b1, 5'd5, 32'h11})
            begin bad++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/11", rf_we, rf_a3, rf_wd3); end
        step();
        total++; if ({rf_we, busy} !== 2'b00) begin bad++; $display("FAIL single_drained got=%b exp=00", {rf_we, busy}); end
    endtask

    task automatic test_same_cycle();
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hAA;
        b_valid = 1'b1; b_rd = 5'd3; b_data = 32'hBB;
        step();
        idle_inputs();
        q1_addr = 5'd3;
        #1;
        total++; if ({rf_we, rf_a3, rf_wd3} !== {1'b1, 5'd3, 32'hAA})
            begin bad++; $display("FAIL pair_first got=%b/%0d/%h exp=1/3/aa", rf_we, rf_a3, rf_wd3); end
`ifdef REG_WB_BYPASS_EN
        total++; if ({q1_hit, q1_data} !== {1'b1, 32'hBB})
            begin bad++; $display("FAIL pair_fwd got=%b/%h exp=1/bb", q1_hit, q1_data); end
`else
        total++; if ({q1_hit, q1_data} !== {1'b0, 32'h0})
            begin bad++; $display("FAIL pair_fwd got=%b/%h exp=0/0", q1_hit, q1_data); end
`endif
        step();
        total++; if ({rf_we, rf_a3, rf_wd3} !== {1'b1, 5'd3, 32'hBB})
            begin bad++; $display("FAIL pair_second got=%b/%0d/%h exp=1/3/bb", rf_we, rf_a3, rf_wd3); end
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL pair_drained got=%0b exp=0", busy); end
        q1_addr = '0;
    endtask

    task automatic test_x0();
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF_FFFF;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%0b exp=1", a_ready); end
        step();
        idle_inputs();
        q1_addr = 5'd0;
        #1;
        total++; if ({rf_we, busy, q1_hit} !== 3'b000)
            begin bad++; $display("FAIL x0_discard got=%b exp=000", {rf_we, busy, q1_hit}); end
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_nowrite got=%0b exp=0", rf_we); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int writes = 0;
        bit stalled = 1'b0;
        bit acc;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (sent < 3) begin
                a_valid = 1'b1; a_rd = 5'(2 * sent + 1); a_data = 32'h100 + 32'(2 * sent + 1);
                b_valid = 1'b1; b_rd = 5'(2 * sent + 2); b_data = 32'h100 + 32'(2 * sent + 2);
            end else begin
                idle_inputs();
            end
            #1;
            acc = (sent < 3) && a_ready && b_ready;
            if (sent < 3 && !a_ready) begin
                stalled = 1'b1;
                total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_pair a=%0b b=%0b exp equal", a_ready, b_ready); end
            end
            if (rf_we) begin
                total++;
                if (rf_a3 !== 5'(writes + 1) || rf_wd3 !== 32'h100 + 32'(writes + 1)) begin
                    bad++; $display("FAIL b2b_order got=%0d/%h exp=%0d/%h", rf_a3, rf_wd3, writes + 1, 32'h100 + 32'(writes + 1));
                end
                writes++;
            end
            step();
            if (acc) sent++;
            if (sent == 3 && !busy) break;
        end
        idle_inputs();
        total++; if (writes != 6) begin bad++; $display("FAIL b2b_count got=%0d exp=6", writes); end
        total++; if (stalled !== 1'b1) begin bad++; $display("FAIL b2b_stall got=%0b exp=1", stalled); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        bit wrote = 1'b0;
        a_valid = 1'b1; a_rd = 5'd9;  a_data = 32'h9;
        b_valid = 1'b1; b_rd = 5'd10; b_data = 32'hA;
        step();
        a_rd = 5'd11; a_data = 32'hB;
        b_rd = 5'd12; b_data = 32'hC;
        step();
        idle_inputs();
        total++; if ({rf_we, rf_a3} !== {1'b1, 5'd10}) begin bad++; $display("FAIL rst_mid_pre got=%b/%0d exp=1/10", rf_we, rf_a3); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({rf_we, busy} !== 2'b00) begin bad++; $display("FAIL rst_mid_async got=%b exp=00", {rf_we, busy}); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (rf_we) wrote = 1'b1;
            step();
        end
        total++; if (wrote !== 1'b0) begin bad++; $display("FAIL rst_mid_stale got=%0b exp=0", wrote); end
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%0b exp=1", a_ready); end
    endtask

    task automatic test_lookup_q2();
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h77;
        step();
        idle_inputs();
        q2_addr = 5'd7;
        #1;
`ifdef REG_WB_BYPASS_EN
        total++; if ({q2_hit, q2_data} !== {1'b1, 32'h77})
            begin bad++; $display("FAIL q2_lookup got=%b/%h exp=1/77", q2_hit, q2_data); end
`else
        total++; if ({q2_hit, q2_data} !== {1'b0, 32'h0})
            begin bad++; $display("FAIL q2_lookup got=%b/%h exp=0/0", q2_hit, q2_data); end
`endif
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL q2_busy got=%0b exp=1", busy); end
        step();
        total++; if ({busy, q2_hit} !== 2'b00) begin bad++; $display("FAIL q2_done got=%b exp=00", {busy, q2_hit}); end
        q2_addr = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_same_cycle();
        test_x0();
        test_back_to_back();
        test_reset_mid();
        test_lookup_q2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
